stage_sequencer: RTL and testbench

Multi-cycle stage controller for the TinyCPU core. It steps the processor through fetch, decode, execute, memory and writeback, and waits on instruction and data memory handshakes. It generates the per-stage enables (issue register, register file write, PC update) and handles run/halt control and a retired-instruction counter. It replaces the free-running stage counter and drives `stage` to every per-stage control block.

---
 rtl/stage_sequencer_if.sv | 42 ++++
 rtl/stage_sequencer.sv | 135 +++++++++++++
 tb/tb_stage_sequencer.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/stage_sequencer_if.sv
// ============================================================================
// Module : stage_sequencer_if
// Brief  : Control/handshake bundle between the stage sequencer and the core.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface stage_sequencer_if #(
  parameter int RETIRE_W = 32
) ();
  localparam int c_num_stages = 5;
  localparam int c_stage_w    = $clog2(c_num_stages);

  logic                 run;
  logic                 halt_req;
  logic                 imem_ack;
  logic                 dmem_ack;
  logic                 instr_is_mem;
  logic                 instr_is_halt;
  logic [c_stage_w-1:0] stage;
  logic                 imem_req;
  logic                 dmem_req;
  logic                 issue_reg_en;
  logic                 rf_write_en;
  logic                 pc_update_en;
  logic                 halted;
  logic [RETIRE_W-1:0]  retired_count;

  modport slave (
    input  run, halt_req, imem_ack, dmem_ack, instr_is_mem, instr_is_halt,
    output stage, imem_req, dmem_req, issue_reg_en, rf_write_en,
           pc_update_en, halted, retired_count
  );

  modport master (
    output run, halt_req, imem_ack, dmem_ack, instr_is_mem, instr_is_halt,
    input  stage, imem_req, dmem_req, issue_reg_en, rf_write_en,
           pc_update_en, halted, retired_count
  );
endinterface

`default_nettype wire

// File: rtl/stage_sequencer.sv
// ============================================================================
// Module : stage_sequencer
// Brief  : TinyCPU multi-cycle stage controller with run/halt and retire count.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stage_sequencer #(
  parameter int RETIRE_W = 32
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  stage_sequencer_if.slave  bus
);

  localparam int c_num_stages = 5;
  localparam int c_stage_w    = $clog2(c_num_stages);

  localparam logic [c_stage_w-1:0] c_stage_fetch     = 3'd0;
  localparam logic [c_stage_w-1:0] c_stage_decode    = 3'd1;
  localparam logic [c_stage_w-1:0] c_stage_execute   = 3'd2;
  localparam logic [c_stage_w-1:0] c_stage_mem       = 3'd3;
  localparam logic [c_stage_w-1:0] c_stage_writeback = 3'd4;

  localparam logic [RETIRE_W-1:0] c_retire_one = {{(RETIRE_W-1){1'b0}}, 1'b1};

  logic [c_stage_w-1:0] r_stage;
  logic                 r_halted;
  logic                 r_pending;
  logic [RETIRE_W-1:0]  r_retired;

  logic [c_stage_w-1:0] w_stage_nxt;
  logic                 w_halted_nxt;
  logic                 w_pending_nxt;
  logic [RETIRE_W-1:0]  w_retired_nxt;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stage   <= c_stage_fetch;
      r_halted  <= 1'b1;
      r_pending <= 1'b0;
      r_retired <= '0;
    end else begin
      r_stage   <= w_stage_nxt;
      r_halted  <= w_halted_nxt;
      r_pending <= w_pending_nxt;
      r_retired <= w_retired_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_stage_nxt   = r_stage;
    w_halted_nxt  = r_halted;
    w_pending_nxt = r_pending;
    w_retired_nxt = r_retired;

    if (r_halted) begin
      w_stage_nxt = c_stage_fetch;
      if (bus.run && !bus.halt_req) begin
        w_halted_nxt = 1'b0;
      end
    end else begin
      // A halt seen mid-instruction is deferred until that instruction retires
      if (bus.halt_req && (r_stage != c_stage_writeback)) begin
        w_pending_nxt = 1'b1;
      end

      case (r_stage)
        c_stage_fetch: begin
          if (bus.imem_ack) begin
            w_stage_nxt = c_stage_decode;
          end
        end
        c_stage_decode: begin
          w_stage_nxt = c_stage_execute;
        end
        c_stage_execute: begin
          w_stage_nxt = bus.instr_is_mem ? c_stage_mem : c_stage_writeback;
        end
        c_stage_mem: begin
          if (bus.dmem_ack) begin
            w_stage_nxt = c_stage_writeback;
          end
        end
        c_stage_writeback: begin
          w_stage_nxt   = c_stage_fetch;
          w_retired_nxt = r_retired + c_retire_one;
          if (bus.instr_is_halt || bus.halt_req || r_pending) begin
            w_halted_nxt  = 1'b1;
            w_pending_nxt = 1'b0;
          end
        end
        default: begin
          w_stage_nxt = c_stage_fetch;
        end
      endcase
    end
  end

  // Output decode: registered state plus same-cycle acks only
  always_comb begin
    bus.stage         = r_stage;
    bus.halted        = r_halted;
    bus.retired_count = r_retired;
    bus.imem_req      = 1'b0;
    bus.dmem_req      = 1'b0;
    bus.issue_reg_en  = 1'b0;
    bus.rf_write_en   = 1'b0;
    bus.pc_update_en  = 1'b0;

    if (!r_halted) begin
      case (r_stage)
        c_stage_fetch: begin
          bus.imem_req     = 1'b1;
          bus.issue_reg_en = bus.imem_ack;
        end
        c_stage_mem: begin
          bus.dmem_req = 1'b1;
        end
        c_stage_writeback: begin
          bus.rf_write_en  = 1'b1;
          bus.pc_update_en = 1'b1;
        end
        default: begin
          bus.imem_req = 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_stage_sequencer.sv
// ============================================================================
// Module : tb_stage_sequencer
// Brief  : Cycle-vector bench for stage_sequencer with a negedge scoreboard.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stage_sequencer;

  localparam int RW = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  stage_sequencer_if #(.RETIRE_W(RW)) bus ();

  stage_sequencer #(.RETIRE_W(RW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // {stage, imem_req, dmem_req, issue_reg_en, rf_write_en, pc_update_en, halted, retired}
  logic [12:0] act;
  assign act = {bus.stage, bus.imem_req, bus.dmem_req, bus.issue_reg_en,
                bus.rf_write_en, bus.pc_update_en, bus.halted, bus.retired_count};

  typedef struct {
    bit          run;
    bit          hreq;
    bit          iack;
    bit          dack;
    bit          mem;
    bit          hlt;
    logic [12:0] exp;
  } vec_t;

  typedef struct {
    int          idx;
    logic [12:0] exp;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb[$];
  sb_t  cur;
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic logic [12:0] pk(input int st, input bit ireq, input bit dreq,
                                     input bit iss, input bit wb, input bit hl,
                                     input int ret);
    logic [2:0]    s;
    logic [RW-1:0] r;
    s = st[2:0];
    r = ret[RW-1:0];
    return {s, ireq, dreq, iss, wb, wb, hl, r};
  endfunction

  task automatic add(input bit r, input bit h, input bit ia, input bit da,
                     input bit m, input bit hl_in, input int st, input bit ireq,
                     input bit dreq, input bit iss, input bit wb, input bit hl,
                     input int ret);
    vec_t v;
    v.run = r; v.hreq = h; v.iack = ia; v.dack = da; v.mem = m; v.hlt = hl_in;
    v.exp = pk(st, ireq, dreq, iss, wb, hl, ret);
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [12:0] got, input logic [12:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got %b want %b", name, got, want);
    end
  endtask

  task automatic clear_inputs();
    bus.run = 1'b0; bus.halt_req = 1'b0; bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0; bus.instr_is_mem = 1'b0; bus.instr_is_halt = 1'b0;
  endtask

  task automatic apply(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      @(posedge clk);
      #1;
      bus.run = vecs[i].run;           bus.halt_req      = vecs[i].hreq;
      bus.imem_ack = vecs[i].iack;     bus.dmem_ack      = vecs[i].dack;
      bus.instr_is_mem = vecs[i].mem;  bus.instr_is_halt = vecs[i].hlt;
      sb.push_back('{i, vecs[i].exp});
    end
    @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      cur = sb.pop_front();
      n_vec++;
      if (act !== cur.exp) begin
        n_bad++;
        $display("FAIL vec%0d got %b want %b", cur.idx, act, cur.exp);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  int part1_end;

  initial begin
    clear_inputs();

    //  run hr ia da mm hl | st ir dr is wb hl ret
    add(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 1, 0);  // idle while halted
    add(1, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 1, 0);  // run+halt collision
    add(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 1, 0);  // still halted
    add(1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 1, 0);  // run pulse
    add(0, 0, 1, 0, 0, 0,   0, 1, 0, 1, 0, 0, 0);  // zero-wait non-mem fetch
    add(0, 0, 1, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0,   2, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0,   4, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0, 1);  // mem instr, imem waits 2
    add(0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0, 1);
    add(0, 0, 1, 0, 0, 0,   0, 1, 0, 1, 0, 0, 1);
    add(0, 0, 0, 1, 1, 0,   1, 0, 0, 0, 0, 0, 1);  // stray dack ignored
    add(0, 0, 0, 0, 1, 0,   2, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 1, 0,   3, 0, 1, 0, 0, 0, 1);
    add(0, 0, 0, 0, 1, 0,   3, 0, 1, 0, 0, 0, 1);
    add(0, 0, 0, 0, 1, 0,   3, 0, 1, 0, 0, 0, 1);
    add(0, 0, 0, 1, 1, 0,   3, 0, 1, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0,   4, 0, 0, 0, 1, 0, 1);
    add(0, 0, 1, 0, 0, 0,   0, 1, 0, 1, 0, 0, 2);  // halt_req in DECODE
    add(0, 1, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 2);
    add(0, 0, 0, 0, 0, 0,   2, 0, 0, 0, 0, 0, 2);
    add(0, 0, 0, 0, 0, 0,   4, 0, 0, 0, 1, 0, 2);
    add(0, 0, 1, 0, 0, 0,   0, 0, 0, 0, 0, 1, 3);  // halted, no fetch
    add(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 1, 3);
    add(1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 1, 3);  // HALT instruction
    add(0, 0, 1, 0, 0, 0,   0, 1, 0, 1, 0, 0, 3);
    add(0, 0, 0, 0, 0, 1,   1, 0, 0, 0, 0, 0, 3);
    add(0, 0, 0, 0, 0, 1,   2, 0, 0, 0, 0, 0, 3);
    add(0, 0, 0, 0, 0, 1,   4, 0, 0, 0, 1, 0, 3);
    add(0, 0, 1, 0, 0, 0,   0, 0, 0, 0, 0, 1, 4);
    add(1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 1, 4);  // 13 more, wrapping at 16
    for (int k = 0; k < 13; k++) begin
      add(0, 0, 1, 0, 0, 0,      0, 1, 0, 1, 0, 0, 4 + k);
      add(1, 0, 0, 0, 0, 0,      1, 0, 0, 0, 0, 0, 4 + k);  // run ignored
      add(0, 0, 0, 0, 0, k == 12, 2, 0, 0, 0, 0, 0, 4 + k);
      add(0, 0, 0, 0, 0, k == 12, 4, 0, 0, 0, 1, 0, 4 + k);
    end
    add(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 1, 17);
    add(1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 1, 17);  // walk into MEM
    add(0, 0, 1, 0, 0, 0,   0, 1, 0, 1, 0, 0, 17);
    add(0, 0, 0, 0, 1, 0,   1, 0, 0, 0, 0, 0, 17);
    add(0, 0, 0, 0, 1, 0,   2, 0, 0, 0, 0, 0, 17);
    add(0, 0, 0, 0, 1, 0,   3, 0, 1, 0, 0, 0, 17);
    part1_end = vecs.size();
    add(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 1, 0);  // after mid-MEM reset
    add(1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0,   0, 1, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0);

    #2 rst_n = 1'b0;
    #1 chk("reset_state", act, pk(0, 0, 0, 0, 0, 1, 0));
    repeat (2) @(negedge clk);
    chk("reset_hold", act, pk(0, 0, 0, 0, 0, 1, 0));
    rst_n = 1'b1;

    apply(0, part1_end);

    #2 rst_n = 1'b0;
    #1 chk("reset_mid_mem", act, pk(0, 0, 0, 0, 0, 1, 0));
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;

    apply(part1_end, vecs.size());

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
